// File: rtl/mul_issue_if.sv
// mul_issue_if: decode, multiplier and writeback buses around the RV32M issue stage.
interface mul_issue_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_rs0;
    logic [31:0] instr_rs1;
    logic        instr_ready;
    logic        illegal;
    logic        flush;
    logic        clear_pipeline;
    logic        mul_initial;
    logic [2:0]  mul_para;
    logic [31:0] mul_rs0;
    logic [31:0] mul_rs1;
    logic        mul_ready;
    logic        mul_finished;
    logic [31:0] mul_data;
    logic        mul_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;

    modport master (
        output instr_valid, instr, instr_rs0, instr_rs1, flush, mul_ready,
               mul_finished, mul_data, wb_ready,
        input  instr_ready, illegal, clear_pipeline, mul_initial, mul_para,
               mul_rs0, mul_rs1, mul_ack, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  instr_valid, instr, instr_rs0, instr_rs1, flush, mul_ready,
               mul_finished, mul_data, wb_ready,
        output instr_ready, illegal, clear_pipeline, mul_initial, mul_para,
               mul_rs0, mul_rs1, mul_ack, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/mul_issue.sv
// mul_issue: queues decoded RV32M ops, issues them to the multiplier and
// routes results to the register file through an in-flight destination-tag FIFO.
module mul_issue #(
    parameter int QDEPTH = 2,
    parameter int TDEPTH = 2
) (
    input logic clk,
    input logic rst,
    mul_issue_if.slave bus
);
    localparam int QW  = $clog2(QDEPTH);
    localparam int QCW = QW + 1;
    localparam int TW  = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;
    localparam int TCW = $clog2(TDEPTH + 1);

    logic [2:0]     q_para [QDEPTH];
    logic [31:0]    q_rs0  [QDEPTH];
    logic [31:0]    q_rs1  [QDEPTH];
    logic [4:0]     q_rd   [QDEPTH];
    logic [QW-1:0]  q_wp, q_rp;
    logic [QCW-1:0] q_cnt;
    logic [4:0]     t_rd   [TDEPTH];
    logic [TW-1:0]  t_wp, t_rp;
    logic [TCW-1:0] t_cnt;
    logic           illegal_q;
    logic           is_m, accept, push, issue, t_empty, ack, t_pop;
    logic [4:0]     head_tag;

    always_comb begin
        is_m     = (bus.instr[6:0] == 7'b0110011) && (bus.instr[31:25] == 7'b0000001);
        accept   = bus.instr_valid & bus.instr_ready & ~bus.flush;
        push     = accept & is_m;
        issue    = (q_cnt != '0) & bus.mul_ready & (t_cnt < TCW'(TDEPTH)) & ~bus.flush;
        head_tag = t_rd[t_rp];
        t_empty  = (t_cnt == '0);
        // With no tag in flight the result has no owner, so it is drained.
        ack      = bus.mul_finished & ~bus.flush & (t_empty | bus.wb_ready | (head_tag == 5'd0));
        t_pop    = ack & ~t_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            q_wp      <= '0;
            q_rp      <= '0;
            q_cnt     <= '0;
            t_wp      <= '0;
            t_rp      <= '0;
            t_cnt     <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (push) begin
                q_para[q_wp] <= bus.instr[14:12];
                q_rs0[q_wp]  <= bus.instr_rs0;
                q_rs1[q_wp]  <= bus.instr_rs1;
                q_rd[q_wp]   <= bus.instr[11:7];
                q_wp         <= q_wp + 1'b1;
            end
            if (issue) begin
                q_rp        <= q_rp + 1'b1;
                t_rd[t_wp]  <= q_rd[q_rp];
                t_wp        <= (t_wp == TW'(TDEPTH - 1)) ? '0 : t_wp + 1'b1;
            end
            if (t_pop)
                t_rp <= (t_rp == TW'(TDEPTH - 1)) ? '0 : t_rp + 1'b1;
            q_cnt     <= q_cnt + QCW'(push) - QCW'(issue);
            t_cnt     <= t_cnt + TCW'(issue) - TCW'(t_pop);
            illegal_q <= accept & ~is_m;
        end
    end

    assign bus.instr_ready    = (q_cnt != QCW'(QDEPTH));
    assign bus.illegal        = illegal_q;
    assign bus.clear_pipeline = bus.flush;
    assign bus.mul_initial    = issue;
    assign bus.mul_para       = issue ? q_para[q_rp] : '0;
    assign bus.mul_rs0        = issue ? q_rs0[q_rp] : '0;
    assign bus.mul_rs1        = issue ? q_rs1[q_rp] : '0;
    assign bus.mul_ack        = ack;
    assign bus.wb_valid       = bus.mul_finished & ~bus.flush & ~t_empty & (head_tag != 5'd0);
    assign bus.wb_rd          = bus.wb_valid ? head_tag : '0;
    assign bus.wb_data        = bus.wb_valid ? bus.mul_data : '0;
endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: directed scenarios plus a random phase, checked against a
// queue/tag scoreboard every cycle.
module tb_mul_issue;
    localparam int QD = 2;
    localparam int TD = 2;

    typedef struct {
        logic [2:0]  para;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } iss_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    iss_t exp_iss [$];
    logic [4:0] tags [$];
    logic exp_ill;

    mul_issue_if bus();

    mul_issue #(.QDEPTH(QD), .TDEPTH(TD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic ism(input logic [31:0] w);
        return (w[6:0] == 7'b0110011) && (w[31:25] == 7'b0000001);
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Samples mid-cycle, compares against the scoreboard, then applies this cycle's updates.
    task automatic smp();
        int qn, tn;
        logic [4:0] head;
        logic v, a, iss, acc;
        iss_t e;
        @(negedge clk);
        if (!rst) begin
            exp_iss.delete();
            tags.delete();
            exp_ill = 1'b0;
            return;
        end
        qn = exp_iss.size();
        tn = tags.size();
        chk("clear_pipeline", 96'(bus.clear_pipeline), 96'(bus.flush));
        chk("instr_ready", 96'(bus.instr_ready), 96'(qn < QD));
        chk("illegal", 96'(bus.illegal), 96'(exp_ill));
        if (bus.mul_finished && !bus.flush) begin
            if (tn == 0) begin
                chk("wb_valid_orphan", 96'(bus.wb_valid), 96'(0));
                chk("mul_ack_orphan", 96'(bus.mul_ack), 96'(1));
            end else begin
                head = tags[0];
                v = (head != 5'd0);
                a = bus.wb_ready || (head == 5'd0);
                chk("wb_valid", 96'(bus.wb_valid), 96'(v));
                chk("mul_ack", 96'(bus.mul_ack), 96'(a));
                if (v) chk("wb_rd_data", {bus.wb_rd, bus.wb_data}, {head, bus.mul_data});
                if (a) void'(tags.pop_front());
            end
        end else begin
            chk("wb_valid_idle", 96'(bus.wb_valid), 96'(0));
            chk("mul_ack_idle", 96'(bus.mul_ack), 96'(0));
        end
        iss = (qn != 0) && bus.mul_ready && (tn < TD) && !bus.flush;
        chk("mul_initial", 96'(bus.mul_initial), 96'(iss));
        if (iss && exp_iss.size() != 0) begin
            e = exp_iss.pop_front();
            chk("issue_bus", {bus.mul_para, bus.mul_rs0, bus.mul_rs1}, {e.para, e.a, e.b});
            tags.push_back(e.rd);
        end else if (!iss) begin
            chk("idle_bus", {bus.mul_para, bus.mul_rs0, bus.mul_rs1}, 96'(0));
        end
        acc = bus.instr_valid && (qn < QD) && !bus.flush;
        exp_ill = acc && !ism(bus.instr);
        if (acc && ism(bus.instr)) begin
            e.para = bus.instr[14:12];
            e.a    = bus.instr_rs0;
            e.b    = bus.instr_rs1;
            e.rd   = bus.instr[11:7];
            exp_iss.push_back(e);
        end
        if (bus.flush) begin
            exp_iss.delete();
            tags.delete();
        end
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        bus.instr_rs0   = a;
        bus.instr_rs1   = b;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_ill = 1'b0;
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.instr_rs0 = '0;
        bus.instr_rs1 = '0;
        bus.flush = 1'b0;
        bus.mul_ready = 1'b1;
        bus.mul_finished = 1'b0;
        bus.mul_data = '0;
        bus.wb_ready = 1'b1;
        adv(); adv();
        rst = 1'b1;
        smp();
        chk("rst_ready", 96'(bus.instr_ready), 96'(1));
        chk("rst_outs", {bus.illegal, bus.mul_initial, bus.mul_ack, bus.wb_valid}, 96'(0));
        chk("rst_data", {bus.mul_para, bus.mul_rs0, bus.mul_rs1, bus.wb_rd, bus.wb_data}, 96'(0));
        adv();

        // single MUL x5 = 7 * 6
        offer(mk(7'd1, 3'd0, 5'd5), 32'd7, 32'd6);
        smp();
        chk("mul_no_bypass", 96'(bus.mul_initial), 96'(0));
        adv();
        bus.instr_valid = 1'b0;
        smp();
        chk("mul_issue", {bus.mul_initial, bus.mul_para, bus.mul_rs0, bus.mul_rs1}, {1'b1, 3'd0, 32'd7, 32'd6});
        adv();
        bus.mul_finished = 1'b1;
        bus.mul_data = 32'd42;
        smp();
        chk("mul_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.mul_ack}, {1'b1, 5'd5, 32'd42, 1'b1});
        adv();
        bus.mul_finished = 1'b0;

        // back-pressure: three offered with the multiplier busy
        bus.mul_ready = 1'b0;
        offer(mk(7'd1, 3'd0, 5'd10), 32'h11, 32'h12);
        smp(); adv();
        offer(mk(7'd1, 3'd1, 5'd11), 32'h21, 32'h22);
        smp(); adv();
        offer(mk(7'd1, 3'd3, 5'd12), 32'h31, 32'h32);
        smp();
        chk("full_refuse", 96'(bus.instr_ready), 96'(0));
        adv();
        bus.instr_valid = 1'b0;
        bus.mul_ready = 1'b1;
        smp();
        chk("order_first", {bus.mul_initial, bus.mul_para, bus.mul_rs0}, {1'b1, 3'd0, 32'h11});
        adv();
        smp();
        chk("order_second", {bus.mul_initial, bus.mul_para, bus.mul_rs0}, {1'b1, 3'd1, 32'h21});
        adv();
        bus.mul_finished = 1'b1;
        bus.mul_data = 32'd100;
        smp();
        chk("bp_wb0", {bus.wb_valid, bus.wb_rd}, {1'b1, 5'd10});
        adv();
        bus.mul_data = 32'd200;
        smp();
        chk("bp_wb1", {bus.wb_valid, bus.wb_rd}, {1'b1, 5'd11});
        adv();
        bus.mul_finished = 1'b0;

        // DIV x0: drained without a write
        offer(mk(7'd1, 3'd4, 5'd0), 32'd50, 32'd5);
        smp(); adv();
        bus.instr_valid = 1'b0;
        smp(); adv();
        bus.mul_finished = 1'b1;
        bus.mul_data = 32'd10;
        smp();
        chk("x0_drain", {bus.wb_valid, bus.mul_ack}, {1'b0, 1'b1});
        adv();
        bus.mul_finished = 1'b0;

        // writeback stall
        offer(mk(7'd1, 3'd1, 5'd7), 32'd3, 32'd9);
        smp(); adv();
        bus.instr_valid = 1'b0;
        smp(); adv();
        bus.wb_ready = 1'b0;
        bus.mul_finished = 1'b1;
        bus.mul_data = 32'd77;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("wb_stall", {bus.wb_valid, bus.mul_ack}, {1'b1, 1'b0});
            adv();
        end
        bus.wb_ready = 1'b1;
        smp();
        chk("wb_release", {bus.wb_valid, bus.mul_ack, bus.wb_rd}, {1'b1, 1'b1, 5'd7});
        adv();
        bus.mul_finished = 1'b0;

        // flush with two queued and one in flight
        offer(mk(7'd1, 3'd0, 5'd20), 32'd1, 32'd2);
        smp(); adv();
        offer(mk(7'd1, 3'd0, 5'd21), 32'd3, 32'd4);
        smp(); adv();
        bus.mul_ready = 1'b0;
        offer(mk(7'd1, 3'd0, 5'd22), 32'd5, 32'd6);
        smp(); adv();
        bus.instr_valid = 1'b0;
        smp();
        chk("pre_flush_full", 96'(bus.instr_ready), 96'(0));
        adv();
        bus.flush = 1'b1;
        bus.mul_ready = 1'b1;
        bus.mul_finished = 1'b1;
        bus.mul_data = 32'd99;
        smp();
        chk("flush_cycle", {bus.clear_pipeline, bus.mul_initial, bus.wb_valid, bus.mul_ack}, {1'b1, 1'b0, 1'b0, 1'b0});
        adv();
        bus.flush = 1'b0;
        bus.mul_finished = 1'b0;
        smp();
        chk("post_flush", {bus.instr_ready, bus.mul_initial}, {1'b1, 1'b0});
        adv();
        bus.mul_finished = 1'b1;
        smp();
        chk("orphan_result", {bus.wb_valid, bus.mul_ack}, {1'b0, 1'b1});
        adv();
        bus.mul_finished = 1'b0;

        // non-RV32M word
        offer(32'h0020_83b3, 32'd1, 32'd1);
        smp();
        chk("add_no_pulse_yet", 96'(bus.illegal), 96'(0));
        adv();
        bus.instr_valid = 1'b0;
        smp();
        chk("add_illegal", {bus.illegal, bus.mul_initial}, {1'b1, 1'b0});
        adv();
        smp();
        chk("add_pulse_end", {bus.illegal, bus.mul_initial}, {1'b0, 1'b0});
        adv();

        // reset mid-operation
        bus.mul_ready = 1'b0;
        offer(mk(7'd1, 3'd2, 5'd3), 32'd8, 32'd8);
        smp(); adv();
        smp(); adv();
        bus.instr_valid = 1'b0;
        rst = 1'b0;
        smp(); adv();
        rst = 1'b1;
        bus.mul_ready = 1'b1;
        smp();
        chk("mid_reset", {bus.instr_ready, bus.mul_initial}, {1'b1, 1'b0});
        adv();

        // random traffic: wrap, simultaneous push/pop, flushes
        for (int i = 0; i < 300; i++) begin
            bus.instr_valid  = 1'($urandom_range(0, 1));
            bus.instr        = ($urandom_range(0, 4) == 0) ? mk(7'd0, 3'd0, 5'd1)
                             : mk(7'd1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            bus.instr_rs0    = $urandom;
            bus.instr_rs1    = $urandom;
            bus.mul_ready    = 1'($urandom_range(0, 1));
            bus.mul_finished = (tags.size() != 0) && ($urandom_range(0, 1) == 1);
            bus.mul_data     = $urandom;
            bus.wb_ready     = 1'($urandom_range(0, 1));
            bus.flush        = ($urandom_range(0, 24) == 0);
            smp();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
